// File: rtl/oa22_stim_gen.sv
// Vector sequencer and activity monitor for one OA22 cell under test.
// Optional expected-value checking is built only when OA22_STIM_CHECK_EN is defined.
module oa22_stim_gen #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [1:0]       i_mode,
   input  logic [CNT_W-1:0] i_num_vec,
   input  logic             i_q_in,
   output logic             o_in1,
   output logic             o_in2,
   output logic             o_in3,
   output logic             o_in4,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_toggle_cnt,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic             o_err_flag
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   localparam logic [3:0]       LFSR_SEED = 4'b0001;
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   // Fibonacci x^4+x^3+1, shifting left; never reaches zero from a nonzero seed.
   function automatic logic [3:0] f_lfsr_step(input logic [3:0] s);
      return {s[2:0], s[3] ^ s[2]};
   endfunction

   function automatic logic [3:0] f_gen(input logic [1:0] mode, input logic [3:0] k,
                                        input logic [3:0] lfsr);
      logic [3:0] v;
      case (mode)
         2'd1:    v = k ^ {1'b0, k[3:1]};
         2'd2:    v = lfsr;
         default: v = k;
      endcase
      return v;
   endfunction

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_mode;
   logic [CNT_W-1:0] r_num;
   logic [CNT_W-1:0] r_k;
   logic [CNT_W-1:0] w_k_inc;
   logic             w_last;
   logic             w_launch;
   logic             w_sample;
   logic [3:0]       r_vec;
   logic [3:0]       w_vec_nxt;
   logic [3:0]       r_lfsr;
   logic [3:0]       w_lfsr_nxt;
   logic             r_busy;
   logic             r_done;
   logic             r_prev_q;
   logic [CNT_W-1:0] r_tog;

   assign w_k_inc  = r_k + CNT_ONE;
   assign w_last   = (w_k_inc == r_num);
   assign w_launch = (r_state == ST_IDLE) && i_start;
   assign w_sample = (r_state == ST_RUN);

   always_comb begin
      w_state_nxt = r_state;
      w_vec_nxt   = 4'd0;
      w_lfsr_nxt  = r_lfsr;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_lfsr_nxt = LFSR_SEED;
               if (i_num_vec == CNT_ZERO) begin
                  w_state_nxt = ST_FIN;
               end else begin
                  w_state_nxt = ST_RUN;
                  w_vec_nxt   = f_gen(i_mode, 4'd0, LFSR_SEED);
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (w_last) begin
               w_state_nxt = ST_FIN;
            end else begin
               w_lfsr_nxt = f_lfsr_step(r_lfsr);
               w_vec_nxt  = f_gen(r_mode, w_k_inc[3:0], w_lfsr_nxt);
            end
         end
         ST_FIN:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Counters update at the sampling edge so the totals are final while DONE is high.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_vec    <= 4'd0;
         r_lfsr   <= LFSR_SEED;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_mode   <= 2'd0;
         r_num    <= CNT_ZERO;
         r_k      <= CNT_ZERO;
         r_prev_q <= 1'b0;
         r_tog    <= CNT_ZERO;
      end else begin
         r_state <= w_state_nxt;
         r_vec   <= w_vec_nxt;
         r_lfsr  <= w_lfsr_nxt;
         r_busy  <= (w_state_nxt == ST_RUN);
         r_done  <= (w_state_nxt == ST_FIN);
         if (w_launch) begin
            r_mode <= i_mode;
            r_num  <= i_num_vec;
            r_k    <= CNT_ZERO;
            r_tog  <= CNT_ZERO;
         end else if (w_sample) begin
            r_k      <= w_k_inc;
            r_prev_q <= i_q_in;
            if ((r_k != CNT_ZERO) && (i_q_in != r_prev_q) && (r_tog != CNT_MAX)) begin
               r_tog <= r_tog + CNT_ONE;
            end
         end
      end
   end

`ifdef OA22_STIM_CHECK_EN
   function automatic logic f_oa22(input logic [3:0] v);
      return (v[0] | v[1]) & (v[2] | v[3]);
   endfunction

   logic [CNT_W-1:0] r_err;
   logic             r_err_flag;

   // Compare each sample against the cell function of the vector being driven.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_err      <= CNT_ZERO;
         r_err_flag <= 1'b0;
      end else if (w_launch) begin
         r_err      <= CNT_ZERO;
         r_err_flag <= 1'b0;
      end else if (w_sample && (i_q_in != f_oa22(r_vec))) begin
         r_err_flag <= 1'b1;
         if (r_err != CNT_MAX) begin
            r_err <= r_err + CNT_ONE;
         end
      end
   end

   assign o_err_cnt  = r_err;
   assign o_err_flag = r_err_flag;
`else
   assign o_err_cnt  = CNT_ZERO;
   assign o_err_flag = 1'b0;
`endif

   assign o_in1        = r_vec[0];
   assign o_in2        = r_vec[1];
   assign o_in3        = r_vec[2];
   assign o_in4        = r_vec[3];
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_toggle_cnt = r_tog;

endmodule
